ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter; the transmit counterpart of the cust PS/2 receiver.
//  Sends command bytes (e.g. 0xED set-LEDs, 0xFF reset) to a keyboard or mouse.
//  Drives the open-drain cust_ps2 clk/dat pads through pad enables and receives back through the pad p2c inputs.
//  Sits in the cust peripheral block beside the receiver, which it gates with rx_inhibit_o.
// PARAMETERS
//  INHIBIT_CYC  7200     clk_i cycles the clock line is held low before start (>=100us)
//  TIMEOUT_CYC  1440000  max clk_i cycles between device clock falls, and for the final bus release
//  SYNC_STAGES  2        synchroniser depth on ps2_clk_i/ps2_dat_i (>=2)
// PORTS
//  clk_i         in   1  system clock
//  rst_n_i       in   1  async reset, active low
//  tx_valid_i    in   1  byte to send is valid
//  tx_ready_o    out  1  block can accept a byte (IDLE only)
//  tx_data_i     in   8  byte to send
//  ps2_clk_i     in   1  PS/2 clock from pad (async)
//  ps2_dat_i     in   1  PS/2 data from pad (async)
//  ps2_clk_oe_o  out  1  1 = pull PS/2 clock low (pad c2p tied 0)
//  ps2_dat_oe_o  out  1  1 = pull PS/2 data low (pad c2p tied 0)
//  busy_o        out  1  transfer in progress
//  rx_inhibit_o  out  1  receiver must ignore the bus (= busy_o)
//  done_o        out  1  1-cycle pulse: frame sent and acked
//  ack_err_o     out  1  1-cycle pulse: ack bit sampled high
//  timeout_o     out  1  1-cycle pulse: device stopped clocking
// BEHAVIOUR
//  Reset: both oe=0 (bus released), tx_ready_o=1, busy_o=0, all pulses 0, FSM=IDLE, counters 0.
//  Inputs pass SYNC_STAGES flops, then one edge register; fall = prev&~cur, seen SYNC_STAGES+1 cycles after the pad.
//  Handshake: byte accepted when tx_valid_i&tx_ready_o; it is latched and odd parity computed (par = ~^data).
//  FSM:
//   IDLE     oe=0; on accept -> INHIBIT, cnt=0.
//   INHIBIT  clk_oe=1 for INHIBIT_CYC cycles; dat_oe=1 in the last cycle -> REQ.
//   REQ      clk_oe=0, dat_oe=1 (start bit 0); wait for a device clock fall -> DATA, bit=0.
//   DATA     per fall the frame bit is set: bit k (k=0..7) LSB first, then parity, then stop.
//            Value 0 -> dat_oe=1; value 1 -> dat_oe=0. Stop: dat_oe=0 -> ACK.
//   ACK      on the next fall, sample synced dat: 0 -> ack ok, 1 -> ack_err_o pulse; -> WAITREL.
//   WAITREL  wait for synced clk=1 and dat=1, then done_o pulse (only if acked) -> IDLE.
//  Data changes only while the device holds clock low (immediately after the fall); the device samples on the rise.
//  Fall count: 1-8 data, 9 parity, 10 stop, 11 ack. Bit counter is 4 bits and saturates; no wrap.
//  Timeout: a watchdog counts in REQ/DATA/ACK/WAITREL and clears on each fall.
//   When it reaches TIMEOUT_CYC: both oe=0 same cycle, timeout_o pulse, -> IDLE, byte dropped.
//  ack_err_o and timeout_o are mutually exclusive per frame. After ack_err the block still waits in WAITREL for release.
//  tx_valid_i is ignored while busy. A new accept is allowed in the cycle after the return to IDLE.
//  Async reset mid-frame releases both lines immediately with no pulse. The device then times out its own frame.
//  Counter widths are $clog2(param+1). busy_o=1 in every state except IDLE.
// TESTING
//  1 INHIBIT_CYC=16; send 0xED with the device model clocking at 40 clk_i per half period
//    -> clk_oe low 16 cycles; bits 1,0,1,1,0,1,1,1, parity 1, stop 1; ack 0 -> done_o once, ready back.
//  2 Send 0x00 -> parity 1.
//    Send 0x01 -> parity 0. Device samples each byte intact; both frames give done_o.
//  3 Model leaves ack high -> ack_err_o pulse, no done_o, return to IDLE after the bus goes high.
//  4 Model never clocks after INHIBIT, TIMEOUT_CYC=500 -> timeout_o 500 cycles after entering REQ, both oe=0.
//  5 Assert rst_n_i after the 4th data bit -> oe=0 asynchronously, tx_ready_o=1, no pulses.
//    A next byte 0xF4 then completes normally.
//  6 Hold tx_valid_i high with changing data during a frame -> only the first byte is sent, busy_o=rx_inhibit_o.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send, then shifts
// a byte, odd parity and stop out on device clock falls and checks the device acknowledge.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 7200,
    parameter int TIMEOUT_CYC = 1440000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic [7:0] tx_data_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_dat_oe_o,
    output logic       busy_o,
    output logic       rx_inhibit_o,
    output logic       done_o,
    output logic       ack_err_o,
    output logic       timeout_o
);

    localparam int INH_W = $clog2(INHIBIT_CYC + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_DATA,
        S_ACK,
        S_WAITREL
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [SYNC_STAGES-1:0] r_clkSync;
    logic [SYNC_STAGES-1:0] r_datSync;
    logic                   r_clkPrev;
    logic [7:0]             r_data;
    logic                   r_parity;
    logic [3:0]             r_bitCnt;
    logic [INH_W-1:0]       r_inhCnt;
    logic [TMO_W-1:0]       r_wdog;
    logic                   r_acked;
    logic                   w_clkCur;
    logic                   w_datCur;
    logic                   w_fall;
    logic                   w_accept;
    logic                   w_watched;
    logic                   w_timeout;
    logic                   w_frameBit;

    // Sync flops idle high so that leaving reset never looks like a device clock fall.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_clkSync <= '1;
            r_datSync <= '1;
            r_clkPrev <= 1'b1;
        end else begin
            r_clkSync <= {r_clkSync[SYNC_STAGES-2:0], ps2_clk_i};
            r_datSync <= {r_datSync[SYNC_STAGES-2:0], ps2_dat_i};
            r_clkPrev <= w_clkCur;
        end
    end

    assign w_clkCur  = r_clkSync[SYNC_STAGES-1];
    assign w_datCur  = r_datSync[SYNC_STAGES-1];
    assign w_fall    = r_clkPrev & ~w_clkCur;
    assign w_accept  = tx_valid_i && (r_state == S_IDLE);
    assign w_watched = (r_state == S_REQ) || (r_state == S_DATA) ||
                       (r_state == S_ACK) || (r_state == S_WAITREL);
    assign w_timeout = w_watched && (r_wdog == TMO_MAX);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data   <= '0;
            r_parity <= 1'b0;
            r_bitCnt <= '0;
            r_inhCnt <= '0;
            r_wdog   <= '0;
            r_acked  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data   <= tx_data_i;
                r_parity <= ~^tx_data_i;
            end
            if (r_state == S_INHIBIT) begin
                r_inhCnt <= r_inhCnt + 1'b1;
            end else begin
                r_inhCnt <= '0;
            end
            if (r_state == S_REQ && w_fall) begin
                r_bitCnt <= '0;
            end else if (r_state == S_DATA && w_fall && r_bitCnt != 4'hF) begin
                r_bitCnt <= r_bitCnt + 1'b1;
            end
            if (!w_watched || w_fall || w_timeout) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_accept) begin
                r_acked <= 1'b0;
            end else if (r_state == S_ACK && w_fall && !w_datCur && !w_timeout) begin
                r_acked <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Watchdog expiry overrides every other transition and drops the byte.
    always_comb begin
        w_nextState = r_state;
        if (w_timeout) begin
            w_nextState = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_accept) w_nextState = S_INHIBIT;
                S_INHIBIT: if (r_inhCnt == INH_LAST) w_nextState = S_REQ;
                S_REQ:     if (w_fall) w_nextState = S_DATA;
                S_DATA:    if (w_fall && r_bitCnt == 4'd8) w_nextState = S_ACK;
                S_ACK:     if (w_fall) w_nextState = S_WAITREL;
                S_WAITREL: if (w_clkCur && w_datCur) w_nextState = S_IDLE;
                default:   w_nextState = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_frameBit = 1'b1;
        if (r_bitCnt < 4'd8) begin
            w_frameBit = r_data[r_bitCnt[2:0]];
        end else if (r_bitCnt == 4'd8) begin
            w_frameBit = r_parity;
        end
    end

    always_comb begin
        ps2_clk_oe_o = 1'b0;
        ps2_dat_oe_o = 1'b0;
        tx_ready_o   = 1'b0;
        busy_o       = 1'b1;
        done_o       = 1'b0;
        ack_err_o    = 1'b0;
        timeout_o    = 1'b0;
        case (r_state)
            S_IDLE: begin
                tx_ready_o = 1'b1;
                busy_o     = 1'b0;
            end
            S_INHIBIT: begin
                ps2_clk_oe_o = 1'b1;
                ps2_dat_oe_o = (r_inhCnt == INH_LAST);
            end
            S_REQ:     ps2_dat_oe_o = 1'b1;
            S_DATA:    ps2_dat_oe_o = ~w_frameBit;
            S_ACK:     ack_err_o = w_fall && w_datCur;
            S_WAITREL: done_o = w_clkCur && w_datCur && r_acked;
            default:   busy_o = 1'b1;
        endcase
        if (w_timeout) begin
            ps2_clk_oe_o = 1'b0;
            ps2_dat_oe_o = 1'b0;
            ack_err_o    = 1'b0;
            done_o       = 1'b0;
            timeout_o    = 1'b1;
        end
    end

    assign rx_inhibit_o = busy_o;

endmodule
